// File: rtl/cnn_pkg.sv
// Shared types for the CNN front-end: controller state encoding and coordinate width.
package cnn_pkg;

  localparam int COORD_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } fsm_state_e;

  // A window is complete once two full rows and two columns precede the pixel.
  function automatic logic window_complete(coord_t row, coord_t col);
    return (row >= coord_t'(2)) && (col >= coord_t'(2));
  endfunction

endpackage

// File: rtl/sw_frame_ctrl_if.sv
// Pixel input stream and window output stream of the sliding-window frame controller.
interface sw_frame_ctrl_if;
  import cnn_pkg::*;

  // Both streams: a beat transfers on a rising clk edge where valid && ready;
  // valid must not depend on ready, and payload holds while valid && !ready.
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  coord_t     out_row;
  coord_t     out_col;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_row, out_col
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_row, out_col
  );

endinterface

// File: rtl/sw_frame_ctrl.sv
// Raster-scan frame controller feeding a 3x3 sliding-window datapath and flagging
// each complete window with its top-left coordinates.
module sw_frame_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  sw_frame_ctrl_if.slave       bus,
  output logic                 sw_clr,
  output logic                 sw_en,
  output logic [7:0]           sw_pixel,
  output logic                 busy,
  output logic                 frame_done,
  output fsm_state_e           state_dbg_o
);

  localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
  localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);

  fsm_state_e state_q, state_d;
  coord_t     row_q, row_d;
  coord_t     col_q, col_d;
  coord_t     out_row_q, out_row_d;
  coord_t     out_col_q, out_col_d;
  logic       out_valid_q, out_valid_d;

  logic in_ready_c;
  logic accept;
  logic last_pixel;
  logic win_set;
  logic win_taken;
  logic abort_hit;

  assign abort_hit  = abort && (state_q != ST_IDLE);
  assign accept     = bus.in_valid && in_ready_c;
  assign last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign win_set    = accept && window_complete(row_q, col_q);
  assign win_taken  = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_CLEAR;
        ST_CLEAR:  state_d = ST_STREAM;
        ST_STREAM: if (accept && last_pixel) state_d = ST_DRAIN;
        ST_DRAIN:  if (bus.out_ready) state_d = ST_DONE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Controls that drive the datapath are forced quiet while reset is held.
  always_comb begin
    in_ready_c = 1'b0;
    sw_clr     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sw_clr = !rst;
        busy   = 1'b1;
      end
      ST_STREAM: begin
        in_ready_c = !rst && (!out_valid_q || bus.out_ready);
        busy       = 1'b1;
      end
      ST_DRAIN:  busy = 1'b1;
      ST_DONE:   frame_done = 1'b1;
      default: begin
        in_ready_c = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign sw_en         = accept;
  assign sw_pixel      = bus.in_pixel;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign state_dbg_o   = state_q;

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;

    if (state_q == ST_CLEAR) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A window arriving in the same cycle as a handshake replaces the old one.
    if (abort_hit) begin
      out_valid_d = 1'b0;
    end else if (win_set) begin
      out_valid_d = 1'b1;
      out_row_d   = row_q - coord_t'(2);
      out_col_d   = col_q - coord_t'(2);
    end else if (win_taken) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

endmodule

// File: doc/sw_frame_ctrl.md
SW_FRAME_CTRL -- requirements
Module: sw_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 5: frame width in pixels, legal range 3..255.
REQ-002 SHALL have parameter IMG_H, default 5: frame height in pixels, legal range 3..255.
REQ-003 SHALL have port clk, input, 1: the single clock; one clock domain only.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle frame-start request.
REQ-006 SHALL have port abort, input, 1: one-cycle frame cancel.
REQ-007 SHALL have port in_valid, input, 1: upstream pixel valid.
REQ-008 SHALL have port in_pixel, input, 8: upstream pixel.
REQ-009 SHALL have port in_ready, output, 1: controller accepts a pixel.
REQ-010 SHALL have port sw_clr, output, 1: one-cycle clear to the 3x3 window datapath.
REQ-011 SHALL have port sw_en, output, 1: shift enable to the 3x3 window datapath.
REQ-012 SHALL have port sw_pixel, output, 8: pixel to the window datapath.
REQ-013 SHALL have port out_valid, output, 1: the current window is a complete 3x3 window.
REQ-014 SHALL have port out_ready, input, 1: downstream MAC consumes the window.
REQ-015 SHALL have ports out_row and out_col, output, 8 each: top-left coordinates of the current window.
REQ-016 SHALL have ports busy and frame_done, output, 1 each: frame in progress; one-cycle end-of-frame pulse.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-018 IDLE: start=1 SHALL move to CLEAR; start in any other state SHALL be ignored.
REQ-019 CLEAR SHALL last exactly 1 cycle, assert sw_clr=1, zero row/col counters, then move to STREAM.
REQ-020 In STREAM, in_ready SHALL be (!out_valid || out_ready); in all other states in_ready SHALL be 0.
REQ-021 sw_en SHALL be combinational in_valid && in_ready; sw_pixel SHALL be in_pixel passthrough.
REQ-022 Each accepted pixel (sw_en=1) SHALL advance col; col wraps IMG_W-1 -> 0 and increments row.
REQ-023 On an accepted pixel with row>=2 and col>=2 (pre-increment), out_valid SHALL be set at that edge, with out_row=row-2 and out_col=col-2, so it aligns with the window registers.
REQ-024 out_valid SHALL clear on out_valid && out_ready unless a new valid window is set in the same cycle, in which case it stays 1 with the new coordinates.
REQ-025 While out_valid && !out_ready, in_ready=0 and the window, out_row and out_col SHALL hold stable.
REQ-026 Acceptance of pixel (IMG_H-1, IMG_W-1) SHALL move STREAM -> DRAIN.
REQ-027 DRAIN SHALL move to DONE when out_ready=1.
REQ-028 DONE SHALL last 1 cycle with frame_done=1, then move to IDLE.
REQ-029 busy SHALL be 1 in CLEAR, STREAM and DRAIN, else 0.
REQ-030 Windows per frame SHALL be exactly (IMG_W-2)*(IMG_H-2), in raster order.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE next cycle with out_valid=0 and no frame_done; abort beats start and out_ready in the same cycle.

Reset
REQ-032 rst=1 SHALL force IDLE with counters=0, out_valid=0, out_row=0, out_col=0 and frame_done=0 at the next edge.
REQ-033 During rst, sw_clr=0, sw_en=0 and in_ready=0; mid-frame reset SHALL discard the frame without frame_done.

Structure
REQ-034 FSM state encoding and the coordinate width (8) SHALL live in the shared package cnn_pkg.
REQ-035 The block SHALL instantiate no sub-modules; the integrator SHALL wire sw_en, sw_pixel and sw_clr to sliding_window_3x3 at the top level.

Verification
REQ-036 5x5 frame, in_valid=1 constant, out_ready=1: 9 windows with (row,col) from (0,0) through (2,2) in raster order; frame_done 1 cycle after the last window handshake.
REQ-037 out_ready=0 for 4 cycles at the window (1,1): in_ready=0 and out_row/out_col hold at 1/1 for those 4 cycles; no pixel is lost and the total is still 9 windows.
REQ-038 in_valid toggling every other cycle: no sw_en without in_valid, and the same 9 windows are produced.
REQ-039 abort after 12 accepted pixels: IDLE next cycle, out_valid=0, no frame_done; a new start then yields 9 clean windows with sw_clr pulsed.
REQ-040 rst asserted mid-STREAM, and start asserted during STREAM: all outputs at reset values; the start in STREAM is ignored.
REQ-041 IMG_W=6, IMG_H=3: exactly 4 windows, coordinates (0,0) through (0,3).
